// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: FIFO in, FIFO out, full frame with a zero border.
module sobel_stream_filter #(
  parameter int unsigned IMG_WIDTH   = 540,
  parameter int unsigned IMG_HEIGHT  = 720,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH+2:0] threshold,
  output logic                   in_rd_en,
  input  logic                   in_empty,
  input  logic [PIXEL_WIDTH-1:0] in_dout,
  output logic                   out_wr_en,
  input  logic                   out_full,
  output logic [PIXEL_WIDTH-1:0] out_din,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W      = IMG_WIDTH;
  localparam int unsigned H      = IMG_HEIGHT;
  localparam int unsigned PW     = PIXEL_WIDTH;
  localparam int unsigned GW     = PW + 3;
  localparam int unsigned N      = W * H;
  localparam int unsigned SR_LEN = 2 * W + 3;
  localparam int unsigned SR_IW  = $clog2(SR_LEN);
  localparam int unsigned CNT_W  = $clog2(N + 1);
  localparam int unsigned COL_W  = $clog2(W);
  localparam int unsigned ROW_W  = $clog2(H);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_rd;
  logic               w_wr;
  logic [1:0]         r_mode;
  logic [GW-1:0]      r_thr;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [PW-1:0]      r_sr [SR_LEN];
  logic               r_busy;
  logic               r_done;

  logic [GW-1:0]      w_p00, w_p01, w_p02, w_p10, w_p12, w_p20, w_p21, w_p22;
  logic [GW-1:0]      w_gx, w_gy, w_ax, w_ay, w_sum;
  logic [PW-1:0]      w_val;
  logic               w_border;
  logic               w_last_px;

  // Saturate a non-negative GW-bit value to the pixel range.
  function automatic logic [PW-1:0] sat(input logic [GW-1:0] v);
    return (|v[GW-1:PW]) ? {PW{1'b1}} : v[PW-1:0];
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and FIFO handshakes; FIFO access only when neither side stalls.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FILL;
      S_FILL: begin
        w_rd = !in_empty;
        if (w_rd && r_rd_cnt == CNT_W'(W + 1)) w_next = S_RUN;
      end
      S_RUN: begin
        w_rd = !in_empty && !out_full;
        w_wr = w_rd;
        if (w_rd && r_rd_cnt == CNT_W'(N - 1)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_wr = !out_full;
        if (w_wr && w_last_px) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latched frame configuration, read counter and output position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode   <= '0;
      r_thr    <= '0;
      r_rd_cnt <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mode   <= mode;
        r_thr    <= threshold;
        r_rd_cnt <= '0;
        r_col    <= '0;
        r_row    <= '0;
      end
      if (w_rd) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_wr) begin
        if (r_col == COL_W'(W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == ROW_W'(H - 1)) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  // Two-rows-plus-three window; shifts only when a pixel is popped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SR_LEN); i++) r_sr[i] <= '0;
    end else if (w_rd) begin
      for (int i = int'(SR_LEN) - 1; i > 0; i--) r_sr[i] <= r_sr[i-1];
      r_sr[0] <= in_dout;
    end
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
    end
  end

  // Taps named pRC with R/C = row/col offset + 1; centre sits at index W+1.
  assign w_p00 = GW'(r_sr[SR_IW'(2 * W + 2)]);
  assign w_p01 = GW'(r_sr[SR_IW'(2 * W + 1)]);
  assign w_p02 = GW'(r_sr[SR_IW'(2 * W)]);
  assign w_p10 = GW'(r_sr[SR_IW'(W + 2)]);
  assign w_p12 = GW'(r_sr[SR_IW'(W)]);
  assign w_p20 = GW'(r_sr[SR_IW'(2)]);
  assign w_p21 = GW'(r_sr[SR_IW'(1)]);
  assign w_p22 = GW'(r_sr[SR_IW'(0)]);

  // Gradients in two's complement, magnitudes and mode selection.
  always_comb begin
    w_gx  = (w_p02 + (w_p12 << 1) + w_p22) - (w_p00 + (w_p10 << 1) + w_p20);
    w_gy  = (w_p20 + (w_p21 << 1) + w_p22) - (w_p00 + (w_p01 << 1) + w_p02);
    w_ax  = w_gx[GW-1] ? (GW'(0) - w_gx) : w_gx;
    w_ay  = w_gy[GW-1] ? (GW'(0) - w_gy) : w_gy;
    w_sum = w_ax + w_ay;
    w_val = '0;
    case (r_mode)
      2'b00:   w_val = sat(w_sum);
      2'b01:   w_val = sat(w_ax);
      2'b10:   w_val = sat(w_ay);
      default: w_val = (w_sum > r_thr) ? {PW{1'b1}} : '0;
    endcase
  end

  assign w_border  = (r_row == '0) || (r_row == ROW_W'(H - 1)) ||
                     (r_col == '0) || (r_col == COL_W'(W - 1));
  assign w_last_px = (r_row == ROW_W'(H - 1)) && (r_col == COL_W'(W - 1));

  assign in_rd_en  = w_rd;
  assign out_wr_en = w_wr;
  assign out_din   = (w_wr && !w_border) ? w_val : '0;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Randomised bench for sobel_stream_filter against an image-level Sobel model.
module tb_sobel_stream_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int BUDGET = 2000;

  logic        clock, reset, start;
  logic [1:0]  mode;
  logic [10:0] threshold;
  logic        in_rd_en, in_empty, out_wr_en, out_full, busy, done;
  logic [7:0]  in_dout, out_din;

  int          vectors = 0;
  int          miscompares = 0;
  int          img [H][W];
  logic [7:0]  q [$];
  int          got [$];

  sobel_stream_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .threshold(threshold),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0: constant 100, 1: step at col 4 (0 / 200), 2: ramp col*10, 3: random.
  task automatic fill_img(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c < 4) ? 0 : 200;
          2:       img[r][c] = c * 10;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  function automatic int ref_px(input int r, input int c, input int md, input int thr);
    int gx, gy, ax, ay, s;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1]
       - img[r-1][c-1] - 2 * img[r][c-1] - img[r+1][c-1];
    gy = img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1]
       - img[r-1][c-1] - 2 * img[r-1][c] - img[r-1][c+1];
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    case (md)
      0:       return (s > 255) ? 255 : s;
      1:       return (ax > 255) ? 255 : ax;
      2:       return (ay > 255) ? 255 : ay;
      default: return (s > thr) ? 255 : 0;
    endcase
  endfunction

  // Runs one frame from img; abort_after>0 resets the DUT after that many writes.
  task automatic run_frame(input int md, input int thr, input bit stall,
                           input int abort_after, input bit disturb);
    int  rd_n, wr_n, done_n, viol, post;
    bit  seen_done, finished;
    q.delete();
    got.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) q.push_back(8'(img[r][c]));
    rd_n = 0; wr_n = 0; done_n = 0; viol = 0; post = 0;
    seen_done = 1'b0; finished = 1'b0;
    @(negedge clock);
    start = 1'b1; mode = 2'(md); threshold = 11'(thr);
    in_empty = 1'b1; out_full = 1'b0;
    @(negedge clock);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      in_empty = (q.size() == 0) || (stall && $urandom_range(0, 2) == 0);
      out_full = stall && ($urandom_range(0, 3) == 0);
      in_dout  = (q.size() > 0) ? q[0] : 8'h00;
      if (disturb && cyc == 30) begin
        start = 1'b1; mode = ~2'(md); threshold = 11'($urandom_range(0, 2047));
      end else begin
        start = 1'b0;
      end
      #3;
      if (in_rd_en) begin
        if (in_empty) viol++;
        else begin void'(q.pop_front()); rd_n++; end
      end
      if (out_wr_en) begin
        if (out_full) viol++;
        got.push_back(int'(out_din));
        wr_n++;
      end
      if (done) begin done_n++; seen_done = 1'b1; end
      if (abort_after > 0 && wr_n == abort_after) begin finished = 1'b1; break; end
      if (seen_done) begin
        post++;
        if (post >= 3) begin finished = 1'b1; break; end
      end
      @(negedge clock);
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
    if (abort_after > 0) begin
      in_empty = 1'b0; out_full = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_rd", int'(in_rd_en), 0);
      check("abort_wr", int'(out_wr_en), 0);
      check("abort_done", int'(done), 0);
      check("abort_done_n", done_n, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      in_empty = 1'b1;
    end else begin
      check("writes", wr_n, N);
      check("reads", rd_n, N);
      check("done_pulses", done_n, 1);
      check("stall_violations", viol, 0);
      check("busy_after", int'(busy), 0);
      for (int i = 0; i < got.size() && i < N; i++)
        check($sformatf("px%0d_m%0d", i, md), got[i], ref_px(i / W, i % W, md, thr));
    end
  endtask

  initial begin
    int n255;
    reset = 1'b1; start = 1'b0; mode = 2'b00; threshold = '0;
    in_empty = 1'b0; out_full = 1'b0; in_dout = 8'h00;
    #12;
    check("rst_rd", int'(in_rd_en), 0);
    check("rst_wr", int'(out_wr_en), 0);
    check("rst_din", int'(out_din), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clock);
    reset = 1'b0;
    in_empty = 1'b1; out_full = 1'b1;

    fill_img(0); run_frame(0, 0, 1'b0, 0, 1'b0);
    fill_img(1); run_frame(0, 0, 1'b0, 0, 1'b0);
    n255 = 0;
    foreach (got[i]) if (got[i] == 255) n255++;
    check("step_edge_count", n255, 8);
    run_frame(2, 0, 1'b0, 0, 1'b0);
    run_frame(1, 0, 1'b0, 0, 1'b0);
    fill_img(2); run_frame(3, 79, 1'b0, 0, 1'b0);
    run_frame(3, 80, 1'b0, 0, 1'b0);
    fill_img(1); run_frame(0, 0, 1'b1, 0, 1'b0);
    run_frame(0, 0, 1'b0, 20, 1'b0);
    run_frame(0, 0, 1'b0, 0, 1'b0);
    run_frame(1, 0, 1'b1, 0, 1'b1);
    fill_img(2); run_frame(0, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      fill_img(3);
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
                1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
